// File: rtl/concat_zero_strip.sv
`default_nettype none
// =============================================================================
// Module   : concat_zero_strip
// Brief    : Subtracts a per-frame zero point from every 32-bit lane through a
//            two-stage valid/ready pipeline, framed by an IDLE/RUN/DRAIN FSM.
//            Define CONCAT_ZERO_STRIP_SAT_EN for signed saturation (else wrap).
// Revision : 1.0 - initial release
// =============================================================================
module concat_zero_strip #(
  parameter int PICTURE_NUM       = 1,
  parameter int RE_CHANNEL_IN_NUM = 16,
  localparam int LANES            = PICTURE_NUM * RE_CHANNEL_IN_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           frame_beats,
  input  logic [31:0]           zero_data_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*32-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*32-1:0]   m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [31:0] c_sat_max = 32'h7FFF_FFFF;
  localparam logic [31:0] c_sat_min = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_done;
  logic                 w_done_next;
  logic [15:0]          r_cnt;
  logic [15:0]          r_beats;
  logic [31:0]          r_zero;

  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic [LANES*33-1:0]  r_s1_diff;
  logic [LANES*33-1:0]  w_diff;
  logic [LANES*32-1:0]  w_red;

  logic                 r_m_valid;
  logic                 r_m_last;
  logic [LANES*32-1:0]  r_m_data;

  logic                 w_advance;
  logic                 w_in_hs;
  logic                 w_in_last;
  logic                 w_out_last_hs;
  logic                 w_frame_start;

  // Whole pipeline moves together; it only freezes when the output is blocked.
  assign w_advance     = !r_m_valid || m_ready;
  assign s_ready       = (r_state == RUN) && w_advance && (r_cnt < r_beats);
  assign w_in_hs       = s_valid && s_ready;
  assign w_in_last     = (r_cnt == (r_beats - 16'd1));
  assign w_out_last_hs = r_m_valid && m_ready && r_m_last;
  assign w_frame_start = (r_state == IDLE) && start && (frame_beats != 16'd0);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_diff[k*33 +: 33] = {s_data[k*32+31], s_data[k*32 +: 32]}
                              - {r_zero[31], r_zero};
`ifdef CONCAT_ZERO_STRIP_SAT_EN
    logic [32:0] w_s1;
    assign w_s1 = r_s1_diff[k*33 +: 33];
    // Top two bits disagreeing means the value does not fit in 32 signed bits.
    assign w_red[k*32 +: 32] = (w_s1[32:31] == 2'b01) ? c_sat_max :
                               (w_s1[32:31] == 2'b10) ? c_sat_min :
                                                        w_s1[31:0];
`else
    logic w_unused_msb;
    assign w_unused_msb      = r_s1_diff[k*33+32];
    assign w_red[k*32 +: 32] = r_s1_diff[k*33 +: 32];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (frame_beats != 16'd0) begin
            w_state_next = RUN;
          end else begin
            w_done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_in_hs && ((r_cnt + 16'd1) == r_beats)) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_out_last_hs) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 16'd0;
      r_beats <= 16'd0;
      r_zero  <= 32'd0;
    end else if (w_frame_start) begin
      r_cnt   <= 16'd0;
      r_beats <= frame_beats;
      r_zero  <= zero_data_in;
    end else if (w_in_hs) begin
      r_cnt   <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_diff  <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= '0;
    end else if (w_advance) begin
      r_s1_valid <= w_in_hs;
      r_s1_last  <= w_in_hs && w_in_last;
      r_s1_diff  <= w_diff;
      r_m_valid  <= r_s1_valid;
      r_m_last   <= r_s1_valid && r_s1_last;
      r_m_data   <= w_red;
    end
  end

  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_data  = r_m_data;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_concat_zero_strip.sv
`default_nettype none
// =============================================================================
// Module   : tb_concat_zero_strip
// Brief    : Randomized self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_concat_zero_strip;

  localparam int PICTURE_NUM       = 1;
  localparam int RE_CHANNEL_IN_NUM = 16;
  localparam int LANES             = PICTURE_NUM * RE_CHANNEL_IN_NUM;
  localparam int DW                = LANES * 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   frame_beats;
  logic [31:0]   zero_data_in;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t exp_q[$];

  concat_zero_strip #(
    .PICTURE_NUM       (PICTURE_NUM),
    .RE_CHANNEL_IN_NUM (RE_CHANNEL_IN_NUM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frame_beats  (frame_beats),
    .zero_data_in (zero_data_in),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer difference, then saturate or wrap to 32 bits.
  function automatic logic [31:0] ref_lane(input logic [31:0] x, input logic [31:0] z);
    longint d;
    longint hi;
    longint lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    d  = longint'($signed(x)) - longint'($signed(z));
`ifdef CONCAT_ZERO_STRIP_SAT_EN
    if (d > hi) return 32'h7FFF_FFFF;
    if (d < lo) return 32'h8000_0000;
`else
    if (d > hi || d < lo) d = d & 64'h0000_0000_FFFF_FFFF;
`endif
    return d[31:0];
  endfunction

  // rmode: 0 always ready, 1 toggling 1010, 2 random.
  // dmode: 1 lanes = base+index (valid held), 2 lanes = base (valid held), 3 random.
  task automatic run_frame(input logic [31:0] zero, input int beats, input int rmode,
                           input int dmode, input logic [31:0] base, input bit inject);
    int acc = 0;
    int outc = 0;
    int cyc = 0;
    int first_acc = -1;
    int first_val = -1;
    bit fin = 0;
    bit timed_out = 0;
    logic [DW-1:0] expd;
    logic [31:0] lane;
    exp_q.delete();
    start        = 1'b1;
    zero_data_in = zero;
    frame_beats  = 16'(beats);
    s_valid      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_run", busy, 1'b1);
    check("done_low", done, 1'b0);
    while (!fin) begin
      if (cyc >= 600) begin
        check("timeout", 1'b0, 1'b1);
        timed_out = 1;
        break;
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom % 2);
      endcase
      start        = inject && (cyc == 3);
      zero_data_in = (inject && cyc == 3) ? ~zero : zero;
      frame_beats  = (inject && cyc == 3) ? 16'(beats + 3) : 16'(beats);
      s_valid      = (dmode == 3) ? ($urandom % 4 != 0) : 1'b1;
      for (int k = 0; k < LANES; k++) begin
        case (dmode)
          1: lane = base + 32'(acc);
          2: lane = base;
          default: begin
            case ($urandom % 6)
              0:       lane = 32'h7FFF_FFFF;
              1:       lane = 32'h8000_0000;
              default: lane = $urandom;
            endcase
          end
        endcase
        s_data[k*32 +: 32] = lane;
      end
      #1;
      if (m_valid) begin
        if (first_val < 0) first_val = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_valid", 1'b1, 1'b0);
        end else begin
          check("data", m_data, exp_q[0].data);
          if (m_ready) begin
            check("last", m_last, exp_q[0].last);
            fin = exp_q[0].last;
            void'(exp_q.pop_front());
            outc++;
          end
        end
      end
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        for (int k = 0; k < LANES; k++)
          expd[k*32 +: 32] = ref_lane(s_data[k*32 +: 32], zero);
        if (acc < beats) exp_q.push_back('{data: expd, last: (acc == beats - 1)});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    s_valid = 1'b1;
    #1;
    if (!timed_out) begin
      check("done_pulse", done, 1'b1);
      check("idle_after", busy, 1'b0);
      check("valid_after", m_valid, 1'b0);
      check("no_excess", s_ready, 1'b0);
      check("accepted", 32'(acc), 32'(beats));
      check("delivered", 32'(outc), 32'(beats));
      if (rmode == 0 && dmode != 3) check("latency", 32'(first_val - first_acc), 32'd2);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; frame_beats = '0; zero_data_in = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_m_data", m_data, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(32'd5, 4, 0, 1, 32'd100, 1'b0);
    check("lane0_beat_check", {480'd0, ref_lane(32'd100, 32'd5)}, {480'd0, 32'd95});
    run_frame(32'h0000_1234, 8, 1, 3, 32'd0, 1'b0);
    run_frame(32'hFFFF_FFFF, 2, 0, 2, 32'h7FFF_FFFF, 1'b0);
    run_frame(32'h0000_0001, 2, 0, 2, 32'h8000_0000, 1'b0);

    // Zero-length frame
    start = 1'b1; frame_beats = 16'd0; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_valid", m_valid, 1'b0);
    @(negedge clk);
    #1;
    check("zero_done_end", done, 1'b0);
    check("zero_valid2", m_valid, 1'b0);

    run_frame(32'h0000_0042, 6, 2, 3, 32'd0, 1'b1);

    // Reset in the middle of a frame after two accepts
    @(negedge clk);
    start = 1'b1; frame_beats = 16'd6; zero_data_in = 32'd7; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    begin
      int acc2 = 0;
      int guard = 0;
      while (acc2 < 2 && guard < 50) begin
        #1;
        if (s_ready) acc2++;
        @(negedge clk);
        guard++;
      end
      check("mid_accepts", 32'(acc2), 32'd2);
    end
    rst = 1'b1;
    #1;
    check("mrst_m_valid", m_valid, 1'b0);
    check("mrst_s_ready", s_ready, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_m_last", m_last, 1'b0);
    check("mrst_m_data", m_data, '0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mrst_no_done", done, 1'b0);
    check("mrst_valid", m_valid, 1'b0);
    run_frame(32'd0, 1, 0, 3, 32'd0, 1'b0);

    for (int f = 0; f < 4; f++)
      run_frame($urandom, int'($urandom_range(1, 10)), 2, 3, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/concat_zero_strip.md
CONCAT_ZERO_STRIP -- requirements
Module: concat_zero_strip

Interface
REQ-001 SHALL have parameter RE_CHANNEL_IN_NUM, default 16: channels per picture.
REQ-002 SHALL define LANES = `PICTURE_NUM*RE_CHANNEL_IN_NUM` 32-bit lanes, with lane k at bits [k*32+31 : k*32].
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle frame start request; honoured only in IDLE.
REQ-006 frame_beats  in  16  beats in the frame; sampled on an accepted start.
REQ-007 zero_data_in  in  32  zero point; sampled on an accepted start.
REQ-008 s_valid  in  1  input beat valid.
REQ-009 s_ready  out  1  input beat accepted when s_valid && s_ready.
REQ-010 s_data  in  LANES*32  packed signed input lanes.
REQ-011 m_valid  out  1  output beat valid.
REQ-012 m_ready  in  1  downstream accepts when m_valid && m_ready.
REQ-013 m_data  out  LANES*32  packed signed output lanes.
REQ-014 m_last  out  1  high with the final output beat of the frame.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse when the frame completes.

Function
REQ-017 SHALL compute each lane as m_data lane k = s_data lane k minus the latched zero point, in signed 33-bit arithmetic before width reduction.
REQ-018 SHALL use a two-stage pipeline: stage 1 registers the 33-bit differences; stage 2 registers the 32-bit reduced result per REQ-033/034.
REQ-019 SHALL advance the pipeline only when advance = !m_valid || m_ready; while m_valid && !m_ready, m_data and m_last SHALL hold stable.
REQ-020 SHALL drive s_ready = (state==RUN) && advance && (accepted count < frame_beats).
REQ-021 SHALL have a latency of 2 cycles from input handshake to m_valid when m_ready is held high; sustained throughput SHALL be 1 beat/cycle.
REQ-022 SHALL have FSM states IDLE, RUN and DRAIN.
REQ-023 IDLE: start with frame_beats>0 latches zero point and frame_beats, clears the beat counter, and moves to RUN.
REQ-024 IDLE: start with frame_beats==0 pulses done the next cycle, stays IDLE, and emits no beats.
REQ-025 RUN: each input handshake increments the 16-bit beat counter; the handshake making count == frame_beats moves to DRAIN in the same edge.
REQ-026 SHALL tag the beat accepted at count == frame_beats-1 as last; the tag SHALL travel with its data so that m_last is high only on that output beat.
REQ-027 DRAIN: the output handshake with m_last moves to IDLE and asserts done for exactly that next cycle.
REQ-028 SHALL ignore start in RUN/DRAIN; latched zero point and frame_beats SHALL stay unchanged mid-frame.
REQ-029 SHALL ignore s_valid outside RUN; excess input beats beyond frame_beats SHALL never be accepted.
REQ-030 Back-to-back frames: start is accepted in the cycle done is high (state is IDLE), so there are no bubbles beyond FSM turnaround.

Reset
REQ-031 On rst high (asynchronous): state SHALL be IDLE; s_ready, m_valid, m_last, busy and done SHALL be 0; m_data, pipeline data, beat counter, latched zero point and latched frame_beats SHALL be 0.
REQ-032 On rst asserted mid-frame: in-flight beats SHALL be discarded with no done pulse; operation resumes only on a new start after release.

Configuration
REQ-033 With macro CONCAT_ZERO_STRIP_SAT_EN defined, stage 2 SHALL saturate the 33-bit difference to signed 32-bit: >2147483647 becomes 32'h7FFFFFFF, and <-2147483648 becomes 32'h80000000.
REQ-034 Without CONCAT_ZERO_STRIP_SAT_EN, stage 2 SHALL take the low 32 bits (two's-complement wrap); latency and handshake SHALL be identical to REQ-033.

Verification
REQ-035 zero=5, frame_beats=4, all lanes 100,101,102,103, m_ready=1 -> m_data lanes 95,96,97,98; first m_valid 2 cycles after the first accept; m_last on beat 4; done one cycle later.
REQ-036 m_ready toggled 1010... over an 8-beat frame -> all 8 beats delivered in order with no loss or duplication, and m_data stable while stalled.
REQ-037 zero=32'hFFFFFFFF (-1), lane=32'h7FFFFFFF -> with SAT_EN 32'h7FFFFFFF; without SAT_EN 32'h80000000.
REQ-038 start with frame_beats=0 -> done pulse the next cycle, m_valid never asserted, busy stays 0.
REQ-039 rst asserted after 2 of 6 beats are accepted -> all outputs 0 immediately; a new start with zero=0 and frame_beats=1 then passes data unchanged with m_last=1.
REQ-040 start pulsed during RUN with a different zero -> ignored; the frame completes using the original zero.
